// File: rtl/video_fetch.sv
// ZX 48K-style video stage: raster timing, VRAM bitmap/attribute fetch, pixel serialiser.
// Optional FLOATING_BUS_EN adds the fbus output (last fetched byte, else 8'hFF).
module video_fetch #(
  parameter int unsigned HCOUNT = 448,
  parameter int unsigned VCOUNT = 312
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic [2:0]  border,
  output logic [12:0] a,
  input  logic [7:0]  q,
  output logic        r,
  output logic        g,
  output logic        b,
  output logic        i,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        int_n
`ifdef FLOATING_BUS_EN
  ,
  output logic [7:0]  fbus
`endif
);

  logic [8:0]  hc_q, hc_d, vc_q, vc_d;
  logic [4:0]  flash_q, flash_d;
  logic [12:0] a_q, a_d;
  logic [7:0]  bmp_q, bmp_d, attr_lat_q, attr_lat_d;
  logic [7:0]  shift_q, shift_d, attr_q, attr_d;
  logic        disp_q, disp_d;
  logic [3:0]  rgbi_q, rgbi_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d, int_n_q, int_n_d;
  logic        hc_wrap, vc_wrap, fetch, pix;
  logic [2:0]  col;

  assign hc_wrap = (hc_q == 9'(HCOUNT - 1));
  assign vc_wrap = (vc_q == 9'(VCOUNT - 1));
  assign fetch   = (vc_q < 9'd192) && (hc_q < 9'd256);

  always_comb begin
    hc_d    = hc_wrap ? 9'd0 : hc_q + 9'd1;
    vc_d    = vc_q;
    flash_d = flash_q;
    if (hc_wrap) begin
      vc_d = vc_wrap ? 9'd0 : vc_q + 9'd1;
      if (vc_wrap) flash_d = flash_q + 5'd1;
    end
  end

  // Each latch lands two ce after its address, so the registered RAM's latency is covered.
  always_comb begin
    a_d        = a_q;
    bmp_d      = bmp_q;
    attr_lat_d = attr_lat_q;
    if (fetch) begin
      unique case (hc_q[2:0])
        3'd0:    a_d = {vc_q[7:6], vc_q[2:0], vc_q[5:3], hc_q[7:3]};
        3'd2: begin
          bmp_d = q;
          a_d   = {3'b110, vc_q[7:3], hc_q[7:3]};
        end
        3'd4:    attr_lat_d = q;
        default: ;
      endcase
    end
  end

  always_comb begin
    shift_d = {shift_q[6:0], 1'b0};
    attr_d  = attr_q;
    disp_d  = disp_q;
    if (hc_q[2:0] == 3'd7) begin
      shift_d = bmp_q;
      attr_d  = attr_lat_q;
      disp_d  = fetch;
    end
  end

  always_comb begin
    hsync_d = (hc_q >= 9'd344) && (hc_q <= 9'd375);
    vsync_d = (vc_q >= 9'd248) && (vc_q <= 9'd251);
    blank_d = ((hc_q >= 9'd320) && (hc_q <= 9'd415)) || ((vc_q >= 9'd248) && (vc_q <= 9'd255));
    int_n_d = !((vc_q == 9'd248) && (hc_q < 9'd32));
  end

  // Colour is {r, g, b, i}; attribute colour fields are ordered b, r, g from bit 0.
  always_comb begin
    pix = shift_q[7] ^ (attr_q[7] & flash_q[4]);
    col = pix ? attr_q[2:0] : attr_q[5:3];
    if (blank_d) begin
      rgbi_d = 4'b0000;
    end else if (disp_q) begin
      rgbi_d = {col[1], col[2], col[0], attr_q[6]};
    end else begin
      rgbi_d = {border[1], border[2], border[0], 1'b0};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hc_q       <= '0;
      vc_q       <= '0;
      flash_q    <= '0;
      a_q        <= '0;
      bmp_q      <= '0;
      attr_lat_q <= '0;
      shift_q    <= '0;
      attr_q     <= '0;
      disp_q     <= 1'b0;
      rgbi_q     <= '0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      blank_q    <= 1'b1;
      int_n_q    <= 1'b1;
    end else if (ce) begin
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      flash_q    <= flash_d;
      a_q        <= a_d;
      bmp_q      <= bmp_d;
      attr_lat_q <= attr_lat_d;
      shift_q    <= shift_d;
      attr_q     <= attr_d;
      disp_q     <= disp_d;
      rgbi_q     <= rgbi_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      blank_q    <= blank_d;
      int_n_q    <= int_n_d;
    end
  end

  assign a     = a_q;
  assign r     = rgbi_q[3];
  assign g     = rgbi_q[2];
  assign b     = rgbi_q[1];
  assign i     = rgbi_q[0];
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign blank = blank_q;
  assign int_n = int_n_q;

`ifdef FLOATING_BUS_EN
  logic [7:0] fbus_q, fbus_d;

  // Bus shows the byte just fetched through the rest of the cell, idle value elsewhere.
  always_comb begin
    fbus_d = 8'hFF;
    if (fetch && (hc_q[2:0] >= 3'd2)) begin
      fbus_d = ((hc_q[2:0] == 3'd2) || (hc_q[2:0] == 3'd4)) ? q : fbus_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fbus_q <= 8'hFF;
    end else if (ce) begin
      fbus_q <= fbus_d;
    end
  end

  assign fbus = fbus_q;
`endif

endmodule

// File: tb/tb_video_fetch.sv
// Scoreboard bench for video_fetch: three instances (full 448x312, 64x256 for frame
// timing, 8x16 for flash), expected values queued per ce-edge index and checked by a monitor.
module tb_video_fetch;

  localparam int FA = 0, FRGBI = 1, FHS = 2, FVS = 3, FBL = 4, FINT = 5, FFB = 6;

  typedef struct {
    int          d;
    int          n;
    int          f;
    logic [15:0] v;
    string       nm;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic [2:0]  border = 3'b010;
  logic [12:0] a_s [3];
  logic [7:0]  q_s [3];
  logic        r_s [3], g_s [3], b_s [3], i_s [3];
  logic        hs_s [3], vs_s [3], bl_s [3], int_s [3];
  logic [7:0]  fb_s [3];
  logic [7:0]  mem [8192];

  exp_t sb[$];
  int   cnt;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  video_fetch u_dut0 (
    .clock(clock), .reset(reset), .ce(ce), .border(border), .a(a_s[0]), .q(q_s[0]),
    .r(r_s[0]), .g(g_s[0]), .b(b_s[0]), .i(i_s[0]), .hsync(hs_s[0]), .vsync(vs_s[0]),
    .blank(bl_s[0]), .int_n(int_s[0])
`ifdef FLOATING_BUS_EN
    , .fbus(fb_s[0])
`endif
  );

  video_fetch #(.HCOUNT(64), .VCOUNT(256)) u_dut1 (
    .clock(clock), .reset(reset), .ce(ce), .border(border), .a(a_s[1]), .q(q_s[1]),
    .r(r_s[1]), .g(g_s[1]), .b(b_s[1]), .i(i_s[1]), .hsync(hs_s[1]), .vsync(vs_s[1]),
    .blank(bl_s[1]), .int_n(int_s[1])
`ifdef FLOATING_BUS_EN
    , .fbus(fb_s[1])
`endif
  );

  video_fetch #(.HCOUNT(8), .VCOUNT(16)) u_dut2 (
    .clock(clock), .reset(reset), .ce(ce), .border(border), .a(a_s[2]), .q(q_s[2]),
    .r(r_s[2]), .g(g_s[2]), .b(b_s[2]), .i(i_s[2]), .hsync(hs_s[2]), .vsync(vs_s[2]),
    .blank(bl_s[2]), .int_n(int_s[2])
`ifdef FLOATING_BUS_EN
    , .fbus(fb_s[2])
`endif
  );

`ifndef FLOATING_BUS_EN
  initial for (int k = 0; k < 3; k++) fb_s[k] = 8'hFF;
`endif

  // Registered RAM read ports, one clock latency.
  always @(posedge clock) begin
    q_s[0] <= mem[a_s[0]];
    q_s[1] <= mem[a_s[1]];
    q_s[2] <= mem[a_s[2]];
  end

  always @(posedge clock) begin
    if (reset) cnt <= 0;
    else if (ce) cnt <= cnt + 1;
  end

  function automatic logic [15:0] observe(input int d, input int f);
    case (f)
      FA:      return {3'b000, a_s[d]};
      FRGBI:   return {12'h000, r_s[d], g_s[d], b_s[d], i_s[d]};
      FHS:     return {15'h0, hs_s[d]};
      FVS:     return {15'h0, vs_s[d]};
      FBL:     return {15'h0, bl_s[d]};
      FINT:    return {15'h0, int_s[d]};
      default: return {8'h00, fb_s[d]};
    endcase
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].n == cnt) begin
          logic [15:0] got;
          got = observe(sb[k].d, sb[k].f);
          checks++;
          if (got !== sb[k].v) begin
            errors++;
            $display("FAIL %s dut%0d n=%0d got %h want %h", sb[k].nm, sb[k].d, sb[k].n, got,
                     sb[k].v);
          end
          sb.delete(k);
        end
      end
    end
  end

  task automatic push(input int d, input int n, input int f, input logic [15:0] v,
                      input string nm);
    exp_t e;
    e.d = d; e.n = n; e.f = f; e.v = v; e.nm = nm;
    sb.push_back(e);
  endtask

  // Cell 0 of line 0: bitmap A5, attr 47 -> white/black with bright.
  task automatic push_line0_common();
    logic [7:0] pat;
    pat = 8'hA5;
    push(0, 1, FA, 16'h0000, "addr_bitmap0");
    push(0, 3, FA, 16'h1800, "addr_attr0");
    for (int j = 0; j < 8; j++)
      push(0, 9 + j, FRGBI, pat[7-j] ? 16'hF : 16'h1, "cell0_pixel");
    push(0, 17, FRGBI, 16'h0, "cell1_paper");
    push(0, 301, FRGBI, 16'h8, "border_red");
    push(0, 321, FRGBI, 16'h0, "blank_rgbi");
  endtask

  task automatic end_phase(input string ph);
    foreach (sb[k]) begin
      checks++;
      errors++;
      $display("FAIL %s_not_reached %s dut%0d n=%0d got cnt=%0d", ph, sb[k].nm, sb[k].d,
               sb[k].n, cnt);
    end
    sb.delete();
  endtask

  initial begin
    logic [7:0] pat;
    logic       inv;
    int         fr [5];
    pat = 8'hA5;
    fr = '{0, 15, 16, 31, 32};
    for (int k = 0; k < 8192; k++) mem[k] = 8'h00;
    mem[13'h0000] = 8'hA5;
    mem[13'h1800] = 8'h47;
    mem[13'h0020] = 8'hA5;
    mem[13'h1820] = 8'hC7;

    // Phase A: ce held high.
    push(0, 0, FA, 16'h0, "rst_a");
    push(0, 0, FRGBI, 16'h0, "rst_rgbi");
    push(0, 0, FBL, 16'h1, "rst_blank");
    push(0, 0, FINT, 16'h1, "rst_int_n");
    push(0, 0, FHS, 16'h0, "rst_hsync");
    push(0, 0, FVS, 16'h0, "rst_vsync");
    push(0, 0, FFB, 16'hFF, "rst_fbus");
    push_line0_common();
    push(0, 257, FA, 16'h181F, "addr_hold");
    push(0, 320, FRGBI, 16'h8, "border_hc319");
    push(0, 320, FBL, 16'h0, "blank_hc319");
    push(0, 321, FBL, 16'h1, "blank_hc320");
    push(0, 416, FBL, 16'h1, "blank_hc415");
    push(0, 417, FBL, 16'h0, "blank_hc416");
    push(0, 417, FRGBI, 16'h8, "border_hc416");
    push(0, 344, FHS, 16'h0, "hsync_hc343");
    push(0, 345, FHS, 16'h1, "hsync_hc344");
    push(0, 376, FHS, 16'h1, "hsync_hc375");
    push(0, 377, FHS, 16'h0, "hsync_hc376");
    push(0, 63 * 448 + 1, FA, 16'h07E0, "addr_vc63");
    push(0, 64 * 448 + 1, FA, 16'h0800, "addr_vc64");
    push(0, 64 * 448 + 3, FA, 16'h1900, "attr_vc64");
`ifdef FLOATING_BUS_EN
    push(0, 1, FFB, 16'hFF, "fbus_hc0");
    push(0, 3, FFB, 16'hA5, "fbus_hc2");
    push(0, 4, FFB, 16'hA5, "fbus_hc3");
    for (int j = 5; j <= 8; j++) push(0, j, FFB, 16'h47, "fbus_attr");
    push(0, 257, FFB, 16'hFF, "fbus_hc256");
`endif
    push(1, 15872, FINT, 16'h1, "int_before");
    push(1, 15873, FINT, 16'h0, "int_fall");
    push(1, 15904, FINT, 16'h0, "int_last");
    push(1, 15905, FINT, 16'h1, "int_rise");
    push(1, 32256, FINT, 16'h1, "int_before2");
    push(1, 32257, FINT, 16'h0, "int_fall2");
    push(1, 15872, FVS, 16'h0, "vsync_vc247");
    push(1, 15873, FVS, 16'h1, "vsync_vc248");
    push(1, 16128, FVS, 16'h1, "vsync_vc251");
    push(1, 16129, FVS, 16'h0, "vsync_vc252");
    push(1, 16384, FBL, 16'h1, "vblank_vc255");
    push(1, 16385, FBL, 16'h0, "vblank_vc0");
    push(1, 15872, FRGBI, 16'h8, "border_vc247");
    push(1, 15873, FRGBI, 16'h0, "vblank_rgbi");
    foreach (fr[x]) begin
      inv = (fr[x] % 32) >= 16;
      for (int j = 0; j < 8; j++)
        push(2, 128 * fr[x] + 73 + j, FRGBI, (pat[7-j] ^ inv) ? 16'hF : 16'h1, "flash_pixel");
    end

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 ce = 1'b1;
    repeat (32400) @(posedge clock);
    #1 ce = 1'b0;
    repeat (2) @(negedge clock);
    end_phase("phaseA");

    // Phase B: reset mid-frame, ce every third clock, same line-0 pixels expected.
    reset = 1'b1;
    #1;
    checks++;
    if (a_s[0] !== 13'h0000) begin
      errors++;
      $display("FAIL midrst_a got %h", a_s[0]);
    end
    checks++;
    if (bl_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_blank got %b", bl_s[0]);
    end
    checks++;
    if (int_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_int_n got %b", int_s[0]);
    end
    checks++;
    if ({r_s[0], g_s[0], b_s[0], i_s[0]} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_rgbi got %b%b%b%b", r_s[0], g_s[0], b_s[0], i_s[0]);
    end
    checks++;
    if (hs_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_hsync got %b", hs_s[0]);
    end
    checks++;
    if (vs_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_vsync got %b", vs_s[0]);
    end
    push_line0_common();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 1050; k++) begin
      @(posedge clock);
      #1 ce = (k % 3 == 0);
    end
    ce = 1'b0;
    repeat (2) @(negedge clock);
    end_phase("phaseB");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
